btn_event_decoder: RTL and testbench

Consumes the clean, synchronous button level produced by the debouncer and turns it into one-cycle event pulses: press, release, click, long-press and double-click. It sits directly downstream of the debouncer and upstream of the user-interface logic. That logic acts on discrete events and never inspects the raw level or timing.

---
 rtl/btn_event_decoder.sv | 87 ++++++++
 tb/tb_btn_event_decoder.sv | 130 +++++++++++++
 2 files changed

// File: rtl/btn_event_decoder.sv
// btn_event_decoder: turns a debounced button level into one-cycle
// press/release/click/long/double pulses plus an idle level.
module btn_event_decoder #(
  parameter int LONG_TIME   = 1_000_000,
  parameter int DOUBLE_TIME = 250_000,
  parameter int CW          = 24
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_btn,
  output logic o_press,
  output logic o_release,
  output logic o_click,
  output logic o_long,
  output logic o_double,
  output logic o_idle
);
  typedef enum logic [2:0] {IDLE, PRESSED, LONG_HELD, WAIT_SECOND, SECOND_PRESS} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] timer_q, timer_d;
  logic prev_q, rise, fall, long_hit, dbl_hit;
  logic [4:0] ev_d, ev_q;
  logic idle_q;
  assign rise     = i_btn & ~prev_q;
  assign fall     = ~i_btn & prev_q;
  assign long_hit = timer_q == CW'(LONG_TIME - 1);
  assign dbl_hit  = timer_q == CW'(DOUBLE_TIME - 1);
  // ev bits: {double, long, click, release, press}
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    ev_d    = '0;
    case (state_q)
      IDLE: if (rise) begin
        ev_d[0] = 1'b1;
        timer_d = '0;
        state_d = PRESSED;
      end
      PRESSED: if (fall) begin
        ev_d[1] = 1'b1;
        timer_d = '0;
        state_d = WAIT_SECOND;
      end else if (long_hit) begin
        ev_d[3] = 1'b1;
        state_d = LONG_HELD;
      end else timer_d = timer_q + CW'(1);
      LONG_HELD: if (fall) begin
        ev_d[1] = 1'b1;
        state_d = IDLE;
      end
      WAIT_SECOND: if (rise) begin
        ev_d[0] = 1'b1;
        timer_d = '0;
        state_d = SECOND_PRESS;
      end else if (dbl_hit) begin
        ev_d[2] = 1'b1;
        state_d = IDLE;
      end else timer_d = timer_q + CW'(1);
      SECOND_PRESS: if (fall) begin
        ev_d[1] = 1'b1;
        ev_d[4] = 1'b1;
        state_d = IDLE;
      end else if (long_hit) begin
        ev_d[3] = 1'b1;
        state_d = LONG_HELD;
      end else timer_d = timer_q + CW'(1);
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      prev_q  <= 1'b0;
      ev_q    <= '0;
      idle_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      prev_q  <= i_btn;
      ev_q    <= ev_d;
      idle_q  <= state_d == IDLE;
    end
  end
  assign {o_double, o_long, o_click, o_release, o_press} = ev_q;
  assign o_idle = idle_q;
endmodule

// File: tb/tb_btn_event_decoder.sv
// tb_btn_event_decoder: directed button sequences; expected pulses are queued
// with their edge numbers and a negedge monitor matches them against the DUT.
module tb_btn_event_decoder;
  localparam int P = 0, R = 1, C = 2, L = 3, D = 4;
  logic i_clk = 0, i_reset_n, i_btn;
  logic o_press, o_release, o_click, o_long, o_double, o_idle;
  int edge_n = 0, checks = 0, passes = 0;
  typedef struct {int c; int k;} ev_t;
  typedef struct {int c; logic v;} id_t;
  ev_t sb[$];
  id_t iq[$];
  string kn[5] = '{"press", "release", "click", "long", "double"};

  btn_event_decoder #(.LONG_TIME(20), .DOUBLE_TIME(10), .CW(24)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_btn(i_btn),
    .o_press(o_press), .o_release(o_release), .o_click(o_click),
    .o_long(o_long), .o_double(o_double), .o_idle(o_idle)
  );

  always #5 i_clk = ~i_clk;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
  endfunction

  function automatic void push_ev(int c, int k);
    sb.push_back('{c, k});
  endfunction

  function automatic void push_idle(int c, logic v);
    iq.push_back('{c, v});
  endfunction

  task automatic step(input logic b);
    i_btn = b;
    @(posedge i_clk);
    edge_n++;
    #1;
  endtask

  task automatic steps(input logic b, input int n);
    for (int i = 0; i < n; i++) step(b);
  endtask

  always @(negedge i_clk) begin
    logic [4:0] v;
    ev_t e;
    v = {o_double, o_long, o_click, o_release, o_press};
    while (sb.size() > 0 && sb[0].c < edge_n) begin
      checks++;
      $display("FAIL missed_%s: not seen, expected at edge %0d", kn[sb[0].k], sb[0].c);
      void'(sb.pop_front());
    end
    for (int k = 0; k < 5; k++) if (v[k]) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_%s: seen at edge %0d, expected none", kn[k], edge_n);
      end else begin
        e = sb.pop_front();
        chk({kn[k], "_edge"}, edge_n, e.c);
        chk({kn[k], "_kind"}, k, e.k);
      end
    end
    if (iq.size() > 0 && iq[0].c == edge_n) begin
      chk("idle", int'(o_idle), int'(iq[0].v));
      void'(iq.pop_front());
    end
  end

  initial begin
    int e, r, m;
    i_btn = 0;
    i_reset_n = 1;
    #1 i_reset_n = 0;
    #1;
    chk("rst_idle", int'(o_idle), 1);
    chk("rst_pulses", int'({o_double, o_long, o_click, o_release, o_press}), 0);
    steps(0, 2);
    i_reset_n = 1;
    // quiet: no pulses, idle held
    e = edge_n;
    push_idle(e + 1, 1); push_idle(e + 25, 1); push_idle(e + 50, 1);
    steps(0, 50);
    // single click
    e = edge_n;
    push_ev(e + 1, P); push_ev(e + 6, R); push_ev(e + 16, C);
    push_idle(e + 1, 0); push_idle(e + 15, 0); push_idle(e + 16, 1);
    steps(1, 5); steps(0, 13);
    // long press, held 30 cycles
    m = edge_n + 1;
    push_ev(m, P); push_ev(m + 20, L); push_ev(m + 30, R);
    push_idle(m + 29, 0); push_idle(m + 30, 1);
    steps(1, 30); steps(0, 3);
    // double click
    m = edge_n + 1;
    push_ev(m, P); push_ev(m + 3, R); push_ev(m + 7, P); push_ev(m + 10, R); push_ev(m + 10, D);
    push_idle(m + 9, 0); push_idle(m + 10, 1);
    steps(1, 3); steps(0, 4); steps(1, 3); steps(0, 12);
    // re-press exactly on the timeout edge counts as the second press
    m = edge_n + 1; r = m + 2;
    push_ev(m, P); push_ev(r, R); push_ev(r + 10, P); push_ev(r + 12, R); push_ev(r + 12, D);
    steps(1, 2); steps(0, 10); steps(1, 2); steps(0, 14);
    // re-press one edge later: click first, then a fresh press
    m = edge_n + 1; r = m + 2;
    push_ev(m, P); push_ev(r, R); push_ev(r + 10, C); push_ev(r + 11, P); push_ev(r + 13, R); push_ev(r + 23, C);
    push_idle(r + 10, 1); push_idle(r + 11, 0);
    steps(1, 2); steps(0, 11); steps(1, 2); steps(0, 15);
    // asynchronous reset while PRESSED, button held through it
    step(1);
    chk("pre_rst_press", int'(o_press), 1);
    chk("pre_rst_idle", int'(o_idle), 0);
    i_reset_n = 0;
    #1;
    chk("async_press", int'(o_press), 0);
    chk("async_idle", int'(o_idle), 1);
    steps(1, 2);
    chk("held_rst_pulses", int'({o_double, o_long, o_click, o_release, o_press}), 0);
    i_reset_n = 1;
    m = edge_n + 1;
    push_ev(m, P); push_ev(m + 20, L); push_ev(m + 25, R);
    push_idle(m + 24, 0); push_idle(m + 25, 1);
    steps(1, 25); steps(0, 5);
    chk("sb_left", sb.size(), 0);
    chk("iq_left", iq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
